zx_ps2_keymatrix: RTL and testbench

PS/2 keyboard front end for the ULA. Deserialises PS/2 device-to-host frames and decodes set-2 make/break scan codes into the 8x5 Spectrum key matrix. Answers ULA port-FE reads with KEYB[4:0] for the half-rows selected by the high address byte. Also exports F1/F11 levels for the core's control logic.

---
 rtl/zx_kbd_pkg.sv | 79 +++++++
 rtl/ps2_rx.sv | 100 ++++++++++
 rtl/zx_ps2_keymatrix.sv | 72 +++++++
 tb/tb_zx_ps2_keymatrix.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zx_kbd_pkg.sv
`timescale 1ns/1ps
// Shared types and the PS/2 set-2 scan-code to Spectrum key-matrix map.
package zx_kbd_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
  } key_pos_t;

  // A scan code can touch up to two matrix positions (cursor keys = CS + digit).
  typedef struct packed {
    key_pos_t k0;
    key_pos_t k1;
  } key_pair_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_F1    = 8'h05;
  localparam logic [7:0] SC_F11   = 8'h78;

  // Column 7 never exists in a 5-column matrix, so it marks "no key".
  localparam key_pos_t KEY_NONE = '{row: 3'd0, col: 3'd7};

  function automatic key_pos_t kp(input logic [2:0] r, input logic [2:0] c);
    key_pos_t k;
    k.row = r;
    k.col = c;
    return k;
  endfunction

  function automatic key_pair_t lookup_key(input logic [7:0] code, input logic ext);
    key_pair_t p;
    p.k0 = KEY_NONE;
    p.k1 = KEY_NONE;
    if (ext) begin
      case (code)
        8'h6B: begin p.k0 = kp(3'd0, 3'd0); p.k1 = kp(3'd3, 3'd4); end
        8'h72: begin p.k0 = kp(3'd0, 3'd0); p.k1 = kp(3'd4, 3'd4); end
        8'h75: begin p.k0 = kp(3'd0, 3'd0); p.k1 = kp(3'd4, 3'd3); end
        8'h74: begin p.k0 = kp(3'd0, 3'd0); p.k1 = kp(3'd4, 3'd2); end
        8'h14: p.k0 = kp(3'd7, 3'd1);
        8'h5A: p.k0 = kp(3'd6, 3'd0);
        default: ;
      endcase
    end else begin
      case (code)
        8'h12, 8'h59: p.k0 = kp(3'd0, 3'd0);
        8'h1A: p.k0 = kp(3'd0, 3'd1);  8'h22: p.k0 = kp(3'd0, 3'd2);
        8'h21: p.k0 = kp(3'd0, 3'd3);  8'h2A: p.k0 = kp(3'd0, 3'd4);
        8'h1C: p.k0 = kp(3'd1, 3'd0);  8'h1B: p.k0 = kp(3'd1, 3'd1);
        8'h23: p.k0 = kp(3'd1, 3'd2);  8'h2B: p.k0 = kp(3'd1, 3'd3);
        8'h34: p.k0 = kp(3'd1, 3'd4);
        8'h15: p.k0 = kp(3'd2, 3'd0);  8'h1D: p.k0 = kp(3'd2, 3'd1);
        8'h24: p.k0 = kp(3'd2, 3'd2);  8'h2D: p.k0 = kp(3'd2, 3'd3);
        8'h2C: p.k0 = kp(3'd2, 3'd4);
        8'h16: p.k0 = kp(3'd3, 3'd0);  8'h1E: p.k0 = kp(3'd3, 3'd1);
        8'h26: p.k0 = kp(3'd3, 3'd2);  8'h25: p.k0 = kp(3'd3, 3'd3);
        8'h2E: p.k0 = kp(3'd3, 3'd4);
        8'h45: p.k0 = kp(3'd4, 3'd0);  8'h46: p.k0 = kp(3'd4, 3'd1);
        8'h3E: p.k0 = kp(3'd4, 3'd2);  8'h3D: p.k0 = kp(3'd4, 3'd3);
        8'h36: p.k0 = kp(3'd4, 3'd4);
        8'h4D: p.k0 = kp(3'd5, 3'd0);  8'h44: p.k0 = kp(3'd5, 3'd1);
        8'h43: p.k0 = kp(3'd5, 3'd2);  8'h3C: p.k0 = kp(3'd5, 3'd3);
        8'h35: p.k0 = kp(3'd5, 3'd4);
        8'h5A: p.k0 = kp(3'd6, 3'd0);  8'h4B: p.k0 = kp(3'd6, 3'd1);
        8'h42: p.k0 = kp(3'd6, 3'd2);  8'h3B: p.k0 = kp(3'd6, 3'd3);
        8'h33: p.k0 = kp(3'd6, 3'd4);
        8'h29: p.k0 = kp(3'd7, 3'd0);  8'h14: p.k0 = kp(3'd7, 3'd1);
        8'h3A: p.k0 = kp(3'd7, 3'd2);  8'h31: p.k0 = kp(3'd7, 3'd3);
        8'h32: p.k0 = kp(3'd7, 3'd4);
        default: ;
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
`timescale 1ns/1ps
// PS/2 device-to-host frame receiver: synchroniser, falling-edge detect,
// start/data/parity/stop FSM with odd-parity check and idle timeout.
// SYNC_STAGES must be at least 2.
module ps2_rx
  import zx_kbd_pkg::*;
#(
  parameter int TIMEOUT     = 14000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fall;
  logic [15:0]            idle_cnt;
  logic                   timeout;
  rx_state_t              state;
  rx_state_t              state_nxt;
  logic [2:0]             bitcnt;
  logic [7:0]             shreg;
  logic                   par;

  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign dat_s     = dat_sync[SYNC_STAGES-1];
  assign fall      = clk_prev & ~clk_s;
  assign timeout   = (idle_cnt >= TIMEOUT_CNT);
  assign byte_data = shreg;

  // Synchronise both lines; idle-high reset avoids a false edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_s;
    end
  end

  // Idle counter: cleared by every PS/2 falling edge, saturates otherwise.
  always_ff @(posedge clk) begin
    if (rst || fall) idle_cnt <= '0;
    else if (idle_cnt != 16'hFFFF) idle_cnt <= idle_cnt + 16'd1;
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: edges advance the frame; a stall in mid-frame drops it.
  always_comb begin
    state_nxt = state;
    if (fall) begin
      case (state)
        IDLE:    if (!dat_s) state_nxt = DATA;
        DATA:    if (bitcnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE && timeout) begin
      state_nxt = IDLE;
    end
  end

  // Bit counter and the one-cycle byte strobe for a well-formed frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt     <= '0;
      byte_valid <= 1'b0;
    end else begin
      if (fall && state == IDLE) bitcnt <= '0;
      else if (fall && state == DATA) bitcnt <= bitcnt + 3'd1;
      byte_valid <= fall && (state == STOP) && dat_s && (^shreg ^ par);
    end
  end

  // Data shifter (LSB first) and parity capture; no reset needed.
  always_ff @(posedge clk) begin
    if (fall && state == DATA)   shreg <= {dat_s, shreg[7:1]};
    if (fall && state == PARITY) par   <= dat_s;
  end

endmodule

// File: rtl/zx_ps2_keymatrix.sv
`timescale 1ns/1ps
// PS/2 keyboard to ZX Spectrum 8x5 key matrix, read through ULA port FE.
module zx_ps2_keymatrix
  import zx_kbd_pkg::*;
#(
  parameter int TIMEOUT     = 14000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  input  logic [7:0] A,
  output logic [4:0] KEYB,
  output logic       F1,
  output logic       F11
);

  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            rel;
  logic            ext;
  logic [7:0][4:0] pressed;
  key_pair_t       keys;

  ps2_rx #(
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk       (CLK),
    .rst       (RESET),
    .ps2_clk   (PS2_CLK),
    .ps2_dat   (PS2_DAT),
    .byte_valid(byte_valid),
    .byte_data (byte_data)
  );

  assign keys = lookup_key(byte_data, ext);

  // Scan-code decoder: prefix flags, then make/break on the mapped keys.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pressed <= '0;
      rel     <= 1'b0;
      ext     <= 1'b0;
      F1      <= 1'b0;
      F11     <= 1'b0;
    end else if (byte_valid) begin
      if (byte_data == SC_BREAK) begin
        rel <= 1'b1;
      end else if (byte_data == SC_EXT) begin
        ext <= 1'b1;
      end else begin
        if (keys.k0.col != KEY_NONE.col) pressed[keys.k0.row][keys.k0.col] <= ~rel;
        if (keys.k1.col != KEY_NONE.col) pressed[keys.k1.row][keys.k1.col] <= ~rel;
        if (!ext && byte_data == SC_F1)  F1  <= ~rel;
        if (!ext && byte_data == SC_F11) F11 <= ~rel;
        rel <= 1'b0;
        ext <= 1'b0;
      end
    end
  end

  // Port-FE column read: AND the inverted rows whose address bit is low.
  always_comb begin
    KEYB = 5'h1F;
    for (int r = 0; r < 8; r++) begin
      if (!A[r]) KEYB = KEYB & ~pressed[r];
    end
  end

endmodule

// File: tb/tb_zx_ps2_keymatrix.sv
`timescale 1ns/1ps
// Bench for zx_ps2_keymatrix: directed vector table, hand-written corner
// sequences and randomised scan-code streams against a key-level model.
module tb_zx_ps2_keymatrix;

  localparam int H = 8;  // CLK cycles per PS/2 clock half-period

  logic       CLK = 1'b0;
  logic       RESET;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] A;
  logic [4:0] KEYB;
  logic       F1;
  logic       F11;

  int n_chk  = 0;
  int n_fail = 0;

  zx_ps2_keymatrix dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .PS2_CLK(PS2_CLK),
    .PS2_DAT(PS2_DAT),
    .A      (A),
    .KEYB   (KEYB),
    .F1     (F1),
    .F11    (F11)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model (key-level) ----------------
  logic [7:0] norm_tab [8][5] = '{
    '{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A},
    '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},
    '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C},
    '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},
    '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36},
    '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},
    '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33},
    '{8'h29, 8'h14, 8'h3A, 8'h31, 8'h32}};
  logic [7:0] ext_code [6] = '{8'h6B, 8'h72, 8'h75, 8'h74, 8'h14, 8'h5A};
  int         ext_k0   [6] = '{0, 0, 0, 0, 36, 30};   // index = row*5+col
  int         ext_k1   [6] = '{19, 24, 23, 22, -1, -1};

  bit m_key [40];
  bit m_rel, m_ext, m_f1, m_f11;

  task automatic model_reset();
    for (int i = 0; i < 40; i++) m_key[i] = 0;
    m_rel = 0; m_ext = 0; m_f1 = 0; m_f11 = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hF0) m_rel = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      if (m_ext) begin
        for (int i = 0; i < 6; i++)
          if (ext_code[i] == b) begin
            m_key[ext_k0[i]] = !m_rel;
            if (ext_k1[i] >= 0) m_key[ext_k1[i]] = !m_rel;
          end
      end else begin
        if (b == 8'h59) m_key[0] = !m_rel;
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 5; c++)
            if (norm_tab[r][c] == b) m_key[r*5+c] = !m_rel;
        if (b == 8'h05) m_f1  = !m_rel;
        if (b == 8'h78) m_f11 = !m_rel;
      end
      m_rel = 0; m_ext = 0;
    end
  endtask

  function automatic logic [4:0] exp_keyb(input logic [7:0] a);
    logic [4:0] k;
    k = 5'h1F;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (!a[r] && m_key[r*5+c]) k[c] = 1'b0;
    return k;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DAT = b;
    repeat (H) @(negedge CLK);
    PS2_CLK = 1'b0;
    repeat (H) @(negedge CLK);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(~^d ^ bad_par);
    ps2_bit(~bad_stop);
    PS2_DAT = 1'b1;
    repeat (H) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [39:0] seq;   // first byte in bits 39:32
    logic [2:0]  n;
    logic [7:0]  a;
    logic [4:0]  keyb;
    logic        f1;
    logic        f11;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [39:0] s, input logic [2:0] n, input logic [7:0] a,
                         input logic [4:0] k, input logic f1, input logic f11);
    vec_t t;
    t.seq = s; t.n = n; t.a = a; t.keyb = k; t.f1 = f1; t.f11 = f11;
    vecs.push_back(t);
  endtask

  logic [7:0] pool[$];
  logic [39:0] s;
  logic [7:0]  b, d;
  int          lat, r, kind;
  bit          bad;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; PS2_CLK = 1'b1; PS2_DAT = 1'b1; A = 8'hFF;
    model_reset();
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    // Reset state
    A = 8'h00; #1;
    check("reset keyb", {3'b0, KEYB}, 8'h1F);
    check("reset f1",   {7'b0, F1},   8'h00);
    check("reset f11",  {7'b0, F11},  8'h00);

    add_vec(40'h1C_00000000, 3'd1, 8'hFD, 5'b11110, 0, 0);
    add_vec(40'h1C_00000000, 3'd1, 8'hFE, 5'b11111, 0, 0);
    add_vec(40'h1CF01C_0000, 3'd3, 8'hFD, 5'b11111, 0, 0);
    add_vec(40'h1CF0_000000, 3'd2, 8'hFD, 5'b11110, 0, 0);
    add_vec(40'hE075_000000, 3'd2, 8'hFE, 5'b11110, 0, 0);
    add_vec(40'hE075_000000, 3'd2, 8'hEF, 5'b10111, 0, 0);
    add_vec(40'hE075_000000, 3'd2, 8'hEE, 5'b10110, 0, 0);
    add_vec(40'hE075E0F075,  3'd5, 8'hEE, 5'b11111, 0, 0);
    add_vec(40'h05_00000000, 3'd1, 8'hFF, 5'b11111, 1, 0);
    add_vec(40'h78_00000000, 3'd1, 8'hFF, 5'b11111, 0, 1);
    add_vec(40'h121A_000000, 3'd2, 8'hFE, 5'b11100, 0, 0);
    add_vec(40'h2914_000000, 3'd2, 8'h7F, 5'b11100, 0, 0);
    add_vec(40'hE014_000000, 3'd2, 8'h7F, 5'b11101, 0, 0);
    add_vec(40'h59_00000000, 3'd1, 8'hFE, 5'b11110, 0, 0);
    add_vec(40'hE06B_000000, 3'd2, 8'hF6, 5'b01110, 0, 0);
    add_vec(40'hE072_000000, 3'd2, 8'hEF, 5'b01111, 0, 0);
    add_vec(40'hE074_000000, 3'd2, 8'hEF, 5'b11011, 0, 0);
    add_vec(40'hE05A_000000, 3'd2, 8'hBF, 5'b11110, 0, 0);
    add_vec(40'h451C_000000, 3'd2, 8'h00, 5'b11110, 0, 0);
    add_vec(40'h1C1C_000000, 3'd2, 8'hFD, 5'b11110, 0, 0);
    add_vec(40'hF01C_000000, 3'd2, 8'hFD, 5'b11111, 0, 0);
    add_vec(40'hE0121A_0000, 3'd3, 8'hFE, 5'b11101, 0, 0);
    add_vec(40'h15_00000000, 3'd1, 8'hFB, 5'b11110, 0, 0);
    add_vec(40'h4D_00000000, 3'd1, 8'hDF, 5'b11110, 0, 0);
    add_vec(40'h35_00000000, 3'd1, 8'hDF, 5'b01111, 0, 0);
    add_vec(40'h32_00000000, 3'd1, 8'h7F, 5'b01111, 0, 0);
    add_vec(40'h0578F005_00, 3'd4, 8'hFF, 5'b11111, 0, 1);

    for (int v = 0; v < vecs.size(); v++) begin
      do_reset();
      s = vecs[v].seq;
      for (int i = 0; i < int'(vecs[v].n); i++) send_frame(s[39-8*i -: 8], 1'b0, 1'b0);
      A = vecs[v].a; #1;
      check($sformatf("vec%0d keyb", v), {3'b0, KEYB}, {3'b0, vecs[v].keyb});
      check($sformatf("vec%0d f1", v),   {7'b0, F1},   {7'b0, vecs[v].f1});
      check($sformatf("vec%0d f11", v),  {7'b0, F11},  {7'b0, vecs[v].f11});
    end

    // Latency: matrix changes SYNC_STAGES+2 CLK after the stop-bit falling edge
    do_reset();
    A = 8'hFD; d = 8'h1C;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(~^d);
    PS2_DAT = 1'b1;
    repeat (H) @(negedge CLK);
    PS2_CLK = 1'b0;
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge CLK); #1;
      if (lat == 0 && KEYB != 5'h1F) lat = n;
    end
    check("latency", 8'(lat), 8'd4);
    check("latency keyb", {3'b0, KEYB}, 8'h1E);
    repeat (2) @(negedge CLK);
    PS2_CLK = 1'b1;
    repeat (H) @(negedge CLK);

    // Bad parity and bad stop bit are dropped; a good frame still decodes
    do_reset();
    A = 8'hFD;
    send_frame(8'h1C, 1'b1, 1'b0); #1;
    check("bad parity", {3'b0, KEYB}, 8'h1F);
    send_frame(8'h1C, 1'b0, 1'b1); #1;
    check("bad stop", {3'b0, KEYB}, 8'h1F);
    send_frame(8'h1B, 1'b0, 1'b0); #1;
    check("after bad frames", {3'b0, KEYB}, 8'h1D);

    // Timeout discards a partial frame
    do_reset();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (15000) @(negedge CLK);
    send_frame(8'h05, 1'b0, 1'b0); #1;
    check("timeout f1 make", {7'b0, F1}, 8'h01);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h05, 1'b0, 1'b0); #1;
    check("f1 break", {7'b0, F1}, 8'h00);
    send_frame(8'h78, 1'b0, 1'b0); #1;
    check("f11 make", {7'b0, F11}, 8'h01);
    A = 8'h00; #1;
    check("f-keys not in matrix", {3'b0, KEYB}, 8'h1F);

    // Reset in the middle of a frame
    do_reset();
    send_frame(8'h29, 1'b0, 1'b0);
    send_frame(8'h05, 1'b0, 1'b0);
    send_frame(8'h78, 1'b0, 1'b0);
    A = 8'h7F; #1;
    check("space held", {3'b0, KEYB}, 8'h1E);
    check("f1 held",    {7'b0, F1},   8'h01);
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b0);
    do_reset(); #1;
    check("midreset keyb", {3'b0, KEYB}, 8'h1F);
    check("midreset f1",   {7'b0, F1},   8'h00);
    check("midreset f11",  {7'b0, F11},  8'h00);
    send_frame(8'h1B, 1'b0, 1'b0);
    A = 8'hFD; #1;
    check("after midreset", {3'b0, KEYB}, 8'h1D);

    // Randomised scan-code stream against the model
    for (int rr = 0; rr < 8; rr++)
      for (int c = 0; c < 5; c++) pool.push_back(norm_tab[rr][c]);
    pool.push_back(8'h59); pool.push_back(8'h05); pool.push_back(8'h78);
    for (int i = 0; i < 4; i++) pool.push_back(ext_code[i]);

    do_reset();
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 99);
      if (r < 20)      b = 8'hF0;
      else if (r < 35) b = 8'hE0;
      else if (r < 85) b = pool[$urandom_range(0, pool.size() - 1)];
      else             b = 8'($urandom_range(0, 255));
      bad  = ($urandom_range(0, 9) == 0);
      kind = $urandom_range(0, 1);
      send_frame(b, bad && kind == 0, bad && kind == 1);
      if (!bad) model_byte(b);
      if ($urandom_range(0, 3) == 0) A = 8'($urandom_range(0, 255));
      else A = ~(8'h01 << $urandom_range(0, 7));
      #1;
      check($sformatf("rand%0d keyb A=%02h", it, A), {3'b0, KEYB}, {3'b0, exp_keyb(A)});
      check($sformatf("rand%0d fkeys", it), {6'b0, F1, F11}, {6'b0, m_f1, m_f11});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
